crg_aes_sequencer: RTL

- Sequences one AES_Composite_enc core to produce a burst of correlated-random blocks in counter mode.
- Each burst loads a key once from a 128-bit seed, then encrypts counter values 0..nblk-1.
- Each ciphertext is delivered on a valid/ready output port.
- Sits between the UART control front end (start/seed/nblk) and the AES core; replaces ad-hoc Krdy/Drdy wiring with one sequenced owner of the core's handshake.

---
 rtl/crg_pkg.sv | 19 +
 rtl/crg_wdog.sv | 33 +++
 rtl/crg_aes_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/crg_pkg.sv
// Shared types and defaults for the correlated-random AES sequencer.
package crg_pkg;

   localparam int CRG_DW          = 128;
   localparam int CRG_CW          = 16;
   localparam int DEFAULT_TIMEOUT = 1023;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KEY   = 3'd1,
      KWAIT = 3'd2,
      ISSUE = 3'd3,
      DWAIT = 3'd4,
      HOLD  = 3'd5,
      ABORT = 3'd6,
      DONE  = 3'd7
   } crg_state_t;

endpackage

// File: rtl/crg_wdog.sv
// Loadable down-counter: expired once TIMEOUT ticks have elapsed since the last load.
module crg_wdog
   import crg_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_tick,
   output logic o_expired
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [TW-1:0] r_cnt;

   // Count down from TIMEOUT while ticking; saturate at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= TW'(TIMEOUT);
      end else if (i_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - TW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/crg_aes_sequencer.sv
// Owns the AES core handshake: loads the burst key once, then encrypts
// counter values 0..nblk-1 and presents each ciphertext on a valid/ready port.
module crg_aes_sequencer
   import crg_pkg::*;
#(
   parameter int DW      = CRG_DW,
   parameter int CW      = CRG_CW,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] seed,
   input  logic [CW-1:0] nblk,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] aes_kin,
   output logic [DW-1:0] aes_din,
   output logic          aes_krdy,
   output logic          aes_drdy,
   output logic          aes_en,
   input  logic [DW-1:0] aes_dout,
   input  logic          aes_kvld,
   input  logic          aes_dvld,
   input  logic          aes_bsy,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] out_idx,
   output logic          out_valid,
   input  logic          out_ready
);

   crg_state_t    r_state;
   crg_state_t    w_state_nxt;

   logic          w_accept;
   logic          w_load;
   logic          w_tick;
   logic          w_expired;
   logic          w_take;
   logic          w_last;
   logic [CW-1:0] w_idx_inc;

   logic [DW-1:0] r_seed;
   logic [CW-1:0] r_nblk;
   logic [CW-1:0] r_idx;
   logic [DW-1:0] r_out_data;
   logic [CW-1:0] r_out_idx;
   logic          r_out_valid;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic          r_krdy;
   logic          r_drdy;
   logic          r_en;

   assign w_take    = r_out_valid && out_ready;
   assign w_idx_inc = r_idx + CW'(1);
   assign w_last    = (w_idx_inc == r_nblk);

   crg_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_tick    (w_tick),
      .o_expired (w_expired)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic plus watchdog load/tick strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      w_tick      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               if (nblk == '0) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = KEY;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         KEY: begin
            w_load      = 1'b1;
            w_state_nxt = KWAIT;
         end
         KWAIT: begin
            w_tick = 1'b1;
            // A valid arriving on the expiry cycle still wins.
            if (aes_kvld) begin
               w_state_nxt = ISSUE;
            end else if (w_expired) begin
               w_state_nxt = ABORT;
            end else begin
               w_state_nxt = KWAIT;
            end
         end
         ISSUE: begin
            if (!aes_bsy) begin
               w_load      = 1'b1;
               w_state_nxt = DWAIT;
            end else begin
               w_state_nxt = ISSUE;
            end
         end
         DWAIT: begin
            w_tick = 1'b1;
            if (aes_dvld) begin
               w_state_nxt = HOLD;
            end else if (w_expired) begin
               w_state_nxt = ABORT;
            end else begin
               w_state_nxt = DWAIT;
            end
         end
         HOLD: begin
            if (w_take) begin
               if (w_last) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = ISSUE;
               end
            end else begin
               w_state_nxt = HOLD;
            end
         end
         ABORT: begin
            w_state_nxt = DONE;
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Core strobes, burst status and burst parameters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en   <= 1'b0;
         r_krdy <= 1'b0;
         r_drdy <= 1'b0;
         r_done <= 1'b0;
         r_busy <= 1'b0;
         r_err  <= 1'b0;
         r_seed <= '0;
         r_nblk <= '0;
         r_idx  <= '0;
      end else begin
         r_en   <= 1'b1;
         r_krdy <= w_accept && (nblk != '0);
         r_drdy <= (r_state == ISSUE) && !aes_bsy;
         r_done <= (r_state == DONE);
         if (w_accept) begin
            r_busy <= 1'b1;
            r_err  <= 1'b0;
            r_seed <= seed;
            r_nblk <= nblk;
            r_idx  <= '0;
         end else begin
            if (r_state == DONE) begin
               r_busy <= 1'b0;
            end
            if (r_state == ABORT) begin
               r_err <= 1'b1;
            end
            if ((r_state == HOLD) && w_take) begin
               r_idx <= w_idx_inc;
            end
         end
      end
   end

   // Output beat capture; data and index only change on a new capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_valid <= 1'b0;
      end else if ((r_state == DWAIT) && aes_dvld) begin
         r_out_data  <= aes_dout;
         r_out_idx   <= r_idx;
         r_out_valid <= 1'b1;
      end else if (((r_state == HOLD) && w_take) || (r_state == ABORT)) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_out_valid;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign aes_kin   = r_seed;
   assign aes_din   = {{(DW-CW){1'b0}}, r_idx};
   assign aes_krdy  = r_krdy;
   assign aes_drdy  = r_drdy;
   assign aes_en    = r_en;
   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;
   assign out_valid = r_out_valid;

endmodule
